decode_sequencer: RTL and testbench

- Upstream control stage for decoder_type_2.
- Walks a program memory of CODE_WIDTH-bit codes and issues each code to the decoder with a one-cycle decode_start pulse.
- Waits a fixed decode latency, then captures the decoder's out_value.
- Packs consecutive captured values into operand pairs (a, b) and hands each pair downstream on a valid/ready handshake.

---
 rtl/decode_sequencer.sv | 179 +++++++++++++++++
 tb/tb_decode_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// ============================================================================
// Module  : decode_sequencer
// Brief   : Fetches program codes, issues them to the decoder, and packs
//           decoded results into operand pairs behind a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int CODE_WIDTH      = 8,
    parameter int PROG_ADDR_WIDTH = 6,
    parameter int PROG_MEM_DELAY  = 2,
    parameter int DECODE_LATENCY  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       run_start,
    input  logic [PROG_ADDR_WIDTH-1:0] prog_len,
    output logic [PROG_ADDR_WIDTH-1:0] mem_prog_addr,
    input  logic [CODE_WIDTH-1:0]      mem_prog_data_out,
    output logic                       decode_start,
    output logic [CODE_WIDTH-1:0]      inp_code,
    input  logic [DATA_WIDTH-1:0]      out_value,
    output logic                       operand_valid,
    input  logic                       operand_ready,
    output logic [DATA_WIDTH-1:0]      operand_a,
    output logic [DATA_WIDTH-1:0]      operand_b,
    output logic                       busy,
    output logic                       run_done
);

    localparam int MAX_WAIT = (PROG_MEM_DELAY > DECODE_LATENCY) ? PROG_MEM_DELAY : DECODE_LATENCY;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(PROG_MEM_DELAY - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(DECODE_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE = PROG_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_OUT     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                     state_q;
    logic [PROG_ADDR_WIDTH-1:0] pc_q;
    logic [PROG_ADDR_WIDTH-1:0] len_q;
    logic [PROG_ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       slot_q;
    logic                       decode_start_q;
    logic [CODE_WIDTH-1:0]      inp_code_q;
    logic                       operand_valid_q;
    logic [DATA_WIDTH-1:0]      operand_a_q;
    logic [DATA_WIDTH-1:0]      operand_b_q;
    logic                       busy_q;
    logic                       run_done_q;
    logic [PROG_ADDR_WIDTH-1:0] pc_d;

    assign pc_d = pc_q + PC_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pc_q            <= '0;
            len_q           <= '0;
            addr_q          <= '0;
            cnt_q           <= '0;
            slot_q          <= 1'b0;
            decode_start_q  <= 1'b0;
            inp_code_q      <= '0;
            operand_valid_q <= 1'b0;
            operand_a_q     <= '0;
            operand_b_q     <= '0;
            busy_q          <= 1'b0;
            run_done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_start) begin
                        len_q  <= prog_len;
                        pc_q   <= '0;
                        slot_q <= 1'b0;
                        busy_q <= 1'b1;
                        if (prog_len == '0) begin
                            state_q    <= S_DONE;
                            run_done_q <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            addr_q  <= '0;
                            cnt_q   <= '0;
                        end
                    end
                end
                // Address was set on entry, so the last FETCH cycle sees valid data.
                S_FETCH: begin
                    if (cnt_q == FETCH_LAST) begin
                        inp_code_q     <= mem_prog_data_out;
                        decode_start_q <= 1'b1;
                        cnt_q          <= '0;
                        state_q        <= S_ISSUE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_ISSUE: begin
                    decode_start_q <= 1'b0;
                    state_q        <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_CAPTURE: begin
                    pc_q   <= pc_d;
                    slot_q <= ~slot_q;
                    if (!slot_q) begin
                        operand_a_q <= out_value;
                    end else begin
                        operand_b_q <= out_value;
                    end
                    if (slot_q || (pc_d == len_q)) begin
                        state_q         <= S_OUT;
                        operand_valid_q <= 1'b1;
                        // Odd-length tail: lone value goes out with a zero partner.
                        if (!slot_q) begin
                            operand_b_q <= '0;
                        end
                    end else begin
                        state_q <= S_FETCH;
                        addr_q  <= pc_d;
                    end
                end
                S_OUT: begin
                    if (operand_ready) begin
                        operand_valid_q <= 1'b0;
                        if (pc_q == len_q) begin
                            state_q    <= S_DONE;
                            run_done_q <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            addr_q  <= pc_q;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_DONE: begin
                    run_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_prog_addr = addr_q;
    assign decode_start  = decode_start_q;
    assign inp_code      = inp_code_q;
    assign operand_valid = operand_valid_q;
    assign operand_a     = operand_a_q;
    assign operand_b     = operand_b_q;
    assign busy          = busy_q;
    assign run_done      = run_done_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_sequencer.sv
// ============================================================================
// Module  : tb_decode_sequencer
// Brief   : Directed self-checking bench for decode_sequencer with program ROM
//           and fixed-latency decoder models.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_decode_sequencer;

    localparam int DW  = 32;
    localparam int CW  = 8;
    localparam int AW  = 6;
    localparam int DL  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run_start = 1'b0;
    logic [AW-1:0] prog_len = '0;
    logic [AW-1:0] mem_prog_addr;
    logic [CW-1:0] mem_data = '0;
    logic          decode_start;
    logic [CW-1:0] inp_code;
    logic [DW-1:0] out_value = '0;
    logic          operand_valid;
    logic          operand_ready = 1'b1;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic          busy;
    logic          run_done;

    decode_sequencer #(
        .DATA_WIDTH     (DW),
        .CODE_WIDTH     (CW),
        .PROG_ADDR_WIDTH(AW),
        .PROG_MEM_DELAY (2),
        .DECODE_LATENCY (DL)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .run_start        (run_start),
        .prog_len         (prog_len),
        .mem_prog_addr    (mem_prog_addr),
        .mem_prog_data_out(mem_data),
        .decode_start     (decode_start),
        .inp_code         (inp_code),
        .out_value        (out_value),
        .operand_valid    (operand_valid),
        .operand_ready    (operand_ready),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .busy             (busy),
        .run_done         (run_done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Program ROM: data valid in the second cycle after an address change.
    logic [CW-1:0] rom [0:63];
    always @(posedge clock) mem_data <= rom[mem_prog_addr];

    // Decoder: result becomes stable DL cycles after it samples decode_start.
    logic [DW-1:0] dec_tab [0:255];
    logic [DW-1:0] dec_pend = '0;
    int            dec_cnt  = 0;
    always @(posedge clock) begin
        if (decode_start) begin
            dec_cnt   <= DL;
            dec_pend  <= dec_tab[inp_code];
            out_value <= 32'hDEADBEEF;
        end else if (dec_cnt != 0) begin
            dec_cnt <= dec_cnt - 1;
            if (dec_cnt == 1) out_value <= dec_pend;
        end
    end

    int            ds_n = 0, done_n = 0, beat_n = 0, valid_n = 0;
    int            ds_cyc[$];
    logic [CW-1:0] ds_code[$];
    logic [DW-1:0] beat_a[$];
    logic [DW-1:0] beat_b[$];
    int            beat_cyc[$];
    int            done_cyc = 0;
    logic          done_busy = 1'b0;

    always @(negedge clock) begin
        if (decode_start) begin
            ds_n = ds_n + 1;
            ds_cyc.push_back(cyc);
            ds_code.push_back(inp_code);
        end
        if (operand_valid) valid_n = valid_n + 1;
        if (operand_valid && operand_ready) begin
            beat_n = beat_n + 1;
            beat_a.push_back(operand_a);
            beat_b.push_back(operand_b);
            beat_cyc.push_back(cyc);
        end
        if (run_done) begin
            done_n    = done_n + 1;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [AW-1:0] len, output int scyc);
        @(negedge clock);
        prog_len  = len;
        run_start = 1'b1;
        scyc      = cyc;
        @(negedge clock);
        run_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_n;
        int i  = 0;
        while (done_n == d0 && i < budget) begin
            @(negedge clock);
            i++;
        end
        if (done_n == d0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clock);
    endtask

    initial begin
        int s, ds0, b0, d0, v0, bad, i;
        logic [DW-1:0] sa, sb;
        logic [AW-1:0] saddr;

        for (int k = 0; k < 64; k++) rom[k] = '0;
        for (int k = 0; k < 256; k++) dec_tab[k] = 32'hBAD00000 | k;
        rom[0] = 8'h05; rom[1] = 8'h23; rom[2] = 8'h47; rom[3] = 8'h6A;
        dec_tab[8'h05] = 32'h11111111;
        dec_tab[8'h23] = 32'h22222222;
        dec_tab[8'h47] = 32'h33333333;
        dec_tab[8'h6A] = 32'h44444444;

        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset mid-run
        d0 = done_n;
        start_run(6'd4, s);
        repeat (12) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_decode_start", {31'd0, decode_start}, 32'd0);
        check("rst_addr", {26'd0, mem_prog_addr}, 32'd0);
        check("rst_inp_code", {24'd0, inp_code}, 32'd0);
        check("rst_valid", {31'd0, operand_valid}, 32'd0);
        check("rst_a", operand_a, 32'd0);
        check("rst_b", operand_b, 32'd0);
        check("rst_run_done", {31'd0, run_done}, 32'd0);
        check("rst_no_done", done_n - d0, 32'd0);

        // Two-code run
        ds0 = ds_n; b0 = beat_n; d0 = done_n;
        start_run(6'd2, s);
        wait_done(100);
        check("two_ds_count", ds_n - ds0, 32'd2);
        check("two_code0", {24'd0, ds_code[ds0]}, 32'h05);
        check("two_code1", {24'd0, ds_code[ds0+1]}, 32'h23);
        check("two_first_issue", ds_cyc[ds0] - s, 32'd3);
        check("two_code_period", ds_cyc[ds0+1] - ds_cyc[ds0], 32'd8);
        check("two_beats", beat_n - b0, 32'd1);
        check("two_a", beat_a[b0], 32'h11111111);
        check("two_b", beat_b[b0], 32'h22222222);
        check("two_done_after_hs", done_cyc - beat_cyc[b0], 32'd1);
        check("two_done_count", done_n - d0, 32'd1);
        check("two_busy_in_done", {31'd0, done_busy}, 32'd1);
        check("two_idle_busy", {31'd0, busy}, 32'd0);

        // Odd length
        b0 = beat_n;
        start_run(6'd3, s);
        wait_done(100);
        check("odd_beats", beat_n - b0, 32'd2);
        check("odd_a0", beat_a[b0], 32'h11111111);
        check("odd_b0", beat_b[b0], 32'h22222222);
        check("odd_a1", beat_a[b0+1], 32'h33333333);
        check("odd_b1", beat_b[b0+1], 32'h00000000);

        // Backpressure with an ignored run_start while busy
        b0 = beat_n; d0 = done_n;
        operand_ready = 1'b0;
        start_run(6'd4, s);
        i = 0;
        while (!operand_valid && i < 100) begin
            @(negedge clock);
            i++;
        end
        check("bp_valid_seen", {31'd0, operand_valid}, 32'd1);
        sa = operand_a; sb = operand_b; saddr = mem_prog_addr;
        ds0 = ds_n; bad = 0;
        check("bp_a", sa, 32'h11111111);
        check("bp_b", sb, 32'h22222222);
        for (int k = 0; k < 10; k++) begin
            run_start = (k == 0);
            prog_len  = 6'd1;
            @(negedge clock);
            if (operand_valid !== 1'b1 || operand_a !== sa || operand_b !== sb ||
                mem_prog_addr !== saddr || decode_start !== 1'b0) bad++;
        end
        run_start = 1'b0;
        check("bp_stable", bad, 32'd0);
        check("bp_no_decode", ds_n - ds0, 32'd0);
        operand_ready = 1'b1;
        wait_done(100);
        check("bp_beats", beat_n - b0, 32'd2);
        check("bp_a1", beat_a[b0+1], 32'h33333333);
        check("bp_b1", beat_b[b0+1], 32'h44444444);
        repeat (20) @(negedge clock);
        check("bp_done_once", done_n - d0, 32'd1);
        check("bp_idle", {31'd0, busy}, 32'd0);

        // Empty run
        ds0 = ds_n; v0 = valid_n; d0 = done_n;
        start_run(6'd0, s);
        wait_done(20);
        check("empty_done", done_n - d0, 32'd1);
        check("empty_no_decode", ds_n - ds0, 32'd0);
        check("empty_no_valid", valid_n - v0, 32'd0);

        // Abort during WAIT, then a clean run
        d0 = done_n; ds0 = ds_n;
        start_run(6'd2, s);
        i = 0;
        while (ds_n == ds0 && i < 50) begin
            @(negedge clock);
            i++;
        end
        check("abort_issue_seen", ds_n - ds0, 32'd1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_no_done", done_n - d0, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        b0 = beat_n;
        start_run(6'd2, s);
        wait_done(100);
        check("restart_done", done_n - d0, 32'd1);
        check("restart_beats", beat_n - b0, 32'd1);
        check("restart_a", beat_a[b0], 32'h11111111);
        check("restart_b", beat_b[b0], 32'h22222222);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
